// File: rtl/rx_pkt_parser.sv
// Byte-serial RX packet parser: validates length/destination, unpacks 16-bit
// fields and strobes en_MNI for the node-info stage on each accepted packet.
module rx_pkt_parser #(
  parameter int                    MEM_WIDTH  = 8,
  parameter int                    WORD_WIDTH = 16,
  parameter logic [WORD_WIDTH-1:0] BCAST_ID   = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [MEM_WIDTH-1:0]  rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_sof,
  input  logic                  rx_eof,
  output logic                  rx_ready,
  output logic                  en_MNI,
  output logic [2:0]            fPktType,
  output logic [WORD_WIDTH-1:0] src_ID,
  output logic [WORD_WIDTH-1:0] ch_ID,
  output logic [WORD_WIDTH-1:0] hops,
  output logic [WORD_WIDTH-1:0] e_max,
  output logic [WORD_WIDTH-1:0] e_min,
  output logic [WORD_WIDTH-1:0] e_threshold,
  output logic [WORD_WIDTH-1:0] timeslot,
  output logic [7:0]            drop_cnt,
  output logic                  pkt_err
);

  // Handshake: a byte moves on a rising clk edge where rx_valid && rx_ready;
  // rx_sof/rx_eof are only meaningful on such a transfer.

  typedef enum logic [1:0] {S_IDLE, S_FIELDS, S_DISCARD, S_EMIT} state_t;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [2:0]            type_q;
  logic                  disc_cnt_q;
  logic [WORD_WIDTH-1:0] sh_q [0:4];
  logic [WORD_WIDTH-1:0] w_c  [0:4];

  logic                  rx_ready_q, en_q, err_q;
  logic [2:0]            ftype_q;
  logic [WORD_WIDTH-1:0] src_q, ch_q, hops_q, emax_q, emin_q, eth_q, ts_q;
  logic [7:0]            drop_q;

  function automatic logic [3:0] pkt_len(input logic [2:0] t);
    case (t)
      3'b000:         pkt_len = 4'd11;
      3'b001:         pkt_len = 4'd5;
      3'b100, 3'b101: pkt_len = 4'd7;
      default:        pkt_len = 4'd0;
    endcase
  endfunction

  logic       xfer, in_fields, last, start;
  logic       restart_drop, start_drop, fld_drop, disc_drop, accept;
  logic [1:0] drop_inc;
  logic [8:0] drop_sum;
  logic [7:0] drop_d;
  logic [2:0] fidx;

  assign xfer      = rx_valid && rx_ready_q;
  assign in_fields = (state_q == S_FIELDS);
  assign last      = (cnt_q == (pkt_len(type_q) - 4'd1));
  assign start     = xfer && rx_sof && (state_q != S_EMIT);

  // A mid-packet sof that itself carries eof can drop two packets in one cycle.
  assign restart_drop = xfer && in_fields && rx_sof;
  assign start_drop   = start && rx_eof;
  assign fld_drop     = xfer && in_fields && !rx_sof && (rx_eof != last);
  assign disc_drop    = xfer && (state_q == S_DISCARD) && !rx_sof && rx_eof && disc_cnt_q;
  assign drop_inc     = 2'(restart_drop) + 2'(start_drop) + 2'(fld_drop) + 2'(disc_drop);
  assign drop_sum     = {1'b0, drop_q} + 9'(drop_inc);
  assign drop_d       = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  // Shadow words with the incoming byte merged, so the eof byte commits directly.
  always_comb begin
    fidx = 3'((cnt_q - 4'd1) >> 1);
    for (int i = 0; i < 5; i++) begin
      w_c[i] = sh_q[i];
      if (in_fields && (cnt_q != 4'd0) && (3'(i) == fidx)) begin
        if (cnt_q[0]) w_c[i][WORD_WIDTH-1 -: MEM_WIDTH] = rx_data;
        else          w_c[i][MEM_WIDTH-1:0]             = rx_data;
      end
    end
  end

  assign accept = !type_q[2] || (w_c[1] == myNodeID) || (w_c[1] == BCAST_ID);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      type_q     <= '0;
      disc_cnt_q <= 1'b0;
      for (int i = 0; i < 5; i++) sh_q[i] <= '0;
      rx_ready_q <= 1'b0;
      en_q       <= 1'b0;
      err_q      <= 1'b0;
      ftype_q    <= '0;
      src_q      <= '0;
      ch_q       <= '0;
      hops_q     <= '0;
      emax_q     <= '0;
      emin_q     <= '0;
      eth_q      <= '0;
      ts_q       <= '0;
      drop_q     <= '0;
    end else begin
      rx_ready_q <= 1'b1;
      en_q       <= 1'b0;
      err_q      <= (drop_inc != 2'd0);
      drop_q     <= drop_d;
      if (start) begin
        type_q     <= rx_data[2:0];
        cnt_q      <= 4'd1;
        disc_cnt_q <= 1'b1;
        if (rx_eof)                            state_q <= S_IDLE;
        else if (pkt_len(rx_data[2:0]) != '0) state_q <= S_FIELDS;
        else                                   state_q <= S_DISCARD;
      end else begin
        case (state_q)
          S_FIELDS: if (xfer) begin
            for (int i = 0; i < 5; i++) sh_q[i] <= w_c[i];
            cnt_q <= cnt_q + 4'd1;
            if (rx_eof) begin
              if (last) begin
                state_q    <= S_EMIT;
                rx_ready_q <= 1'b0;
                en_q       <= accept;
                if (accept) begin
                  ftype_q <= type_q;
                  src_q   <= w_c[0];
                  case (type_q)
                    3'b000: begin
                      hops_q <= w_c[1];
                      emax_q <= w_c[2];
                      emin_q <= w_c[3];
                      eth_q  <= w_c[4];
                    end
                    3'b001:  ch_q   <= w_c[1];
                    3'b100:  ts_q   <= w_c[2];
                    3'b101:  hops_q <= w_c[2];
                    default: ;
                  endcase
                end
              end else begin
                state_q <= S_IDLE;
              end
            end else if (last) begin
              // Too long: already counted, so the tail is not counted again at eof.
              state_q    <= S_DISCARD;
              disc_cnt_q <= 1'b0;
            end
          end
          S_DISCARD: if (xfer && rx_eof) state_q <= S_IDLE;
          S_EMIT:    state_q <= S_IDLE;
          default:   ;
        endcase
      end
    end
  end

  assign rx_ready    = rx_ready_q;
  assign en_MNI      = en_q;
  assign pkt_err     = err_q;
  assign fPktType    = ftype_q;
  assign src_ID      = src_q;
  assign ch_ID       = ch_q;
  assign hops        = hops_q;
  assign e_max       = emax_q;
  assign e_min       = emin_q;
  assign e_threshold = eth_q;
  assign timeslot    = ts_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_rx_pkt_parser.sv
// Directed bench for rx_pkt_parser: packet table plus hand sequences for
// mid-packet sof, stalls, drop saturation and reset.
module tb_rx_pkt_parser;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] myNodeID;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof;
  logic        rx_ready, en_MNI, pkt_err;
  logic [2:0]  fPktType;
  logic [15:0] src_ID, ch_ID, hops, e_max, e_min, e_threshold, timeslot;
  logic [7:0]  drop_cnt;

  rx_pkt_parser dut (
    .clk(clk), .nrst(nrst), .myNodeID(myNodeID),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
    .rx_ready(rx_ready), .en_MNI(en_MNI), .fPktType(fPktType),
    .src_ID(src_ID), .ch_ID(ch_ID), .hops(hops), .e_max(e_max), .e_min(e_min),
    .e_threshold(e_threshold), .timeslot(timeslot),
    .drop_cnt(drop_cnt), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc = 0, en_tot = 0, err_tot = 0, en_cyc = 0, xfer_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (en_MNI) begin
      en_tot <= en_tot + 1;
      en_cyc <= cyc;
    end
    if (pkt_err) err_tot <= err_tot + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [0:11][7:0] b;
    int               n;
    logic [15:0]      node;
    logic             commit;
    logic             err;
    logic [7:0]       drop;
    logic [2:0]       typ;
    logic [15:0]      src, ch, hp, emax, emin, eth, ts;
  } vec_t;

  function automatic vec_t mk(input logic [95:0] b, input int n, input logic [15:0] node,
                              input logic commit, input logic err, input logic [7:0] drop,
                              input logic [2:0] typ, input logic [15:0] src, input logic [15:0] ch,
                              input logic [15:0] hp, input logic [15:0] emax, input logic [15:0] emin,
                              input logic [15:0] eth, input logic [15:0] ts);
    vec_t v;
    v.b = b; v.n = n; v.node = node; v.commit = commit; v.err = err; v.drop = drop;
    v.typ = typ; v.src = src; v.ch = ch; v.hp = hp; v.emax = emax; v.emin = emin;
    v.eth = eth; v.ts = ts;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_fields(input string tag, input logic [2:0] typ, input logic [15:0] src,
                            input logic [15:0] ch, input logic [15:0] hp, input logic [15:0] emax,
                            input logic [15:0] emin, input logic [15:0] eth, input logic [15:0] ts);
    chk({tag, "_type"}, 32'(fPktType), 32'(typ));
    chk({tag, "_src"},  32'(src_ID), 32'(src));
    chk({tag, "_ch"},   32'(ch_ID), 32'(ch));
    chk({tag, "_hops"}, 32'(hops), 32'(hp));
    chk({tag, "_emax"}, 32'(e_max), 32'(emax));
    chk({tag, "_emin"}, 32'(e_min), 32'(emin));
    chk({tag, "_eth"},  32'(e_threshold), 32'(eth));
    chk({tag, "_ts"},   32'(timeslot), 32'(ts));
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic sof, input logic eof);
    int w;
    logic ok;
    rx_data = d; rx_valid = 1'b1; rx_sof = sof; rx_eof = eof;
    w = 0; ok = 1'b0;
    while (!ok && w < 20) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk);
      #1;
      w++;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL byte_xfer: rx_ready got=0 expected=1 within 20 cycles");
    end else begin
      xfer_cyc = cyc;
    end
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
  endtask

  task automatic send_pkt(input logic [0:11][7:0] b, input int n, input bit gap);
    for (int k = 0; k < n; k++) begin
      drive_byte(b[k], k == 0, k == n - 1);
      if (gap && k < n - 1) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
  endtask

  vec_t vt[12];
  int   e0, r0;

  initial begin
    myNodeID = 16'h000C; rx_data = '0; rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;

    vt[0]  = mk(96'h00_0005_0003_0FA0_01F4_03E8_00, 11, 16'h000C, 1, 0, 8'd0, 3'd0, 16'h0005, 16'h0000, 16'h0003, 16'h0FA0, 16'h01F4, 16'h03E8, 16'h0000);
    vt[1]  = mk(96'h01_0007_000C_0000_0000_0000_00,  5, 16'h000C, 1, 0, 8'd0, 3'd1, 16'h0007, 16'h000C, 16'h0003, 16'h0FA0, 16'h01F4, 16'h03E8, 16'h0000);
    vt[2]  = mk(96'h04_0007_000C_0002_0000_0000_00,  7, 16'h000C, 1, 0, 8'd0, 3'd4, 16'h0007, 16'h000C, 16'h0003, 16'h0FA0, 16'h01F4, 16'h03E8, 16'h0002);
    vt[3]  = mk(96'h04_0008_0009_0005_0000_0000_00,  7, 16'h000C, 0, 0, 8'd0, 3'd4, 16'h0007, 16'h000C, 16'h0003, 16'h0FA0, 16'h01F4, 16'h03E8, 16'h0002);
    vt[4]  = mk(96'h04_0008_FFFF_0005_0000_0000_00,  7, 16'h000C, 1, 0, 8'd0, 3'd4, 16'h0008, 16'h000C, 16'h0003, 16'h0FA0, 16'h01F4, 16'h03E8, 16'h0005);
    vt[5]  = mk(96'h05_000A_000C_002A_0000_0000_00,  7, 16'h000C, 1, 0, 8'd0, 3'd5, 16'h000A, 16'h000C, 16'h002A, 16'h0FA0, 16'h01F4, 16'h03E8, 16'h0005);
    vt[6]  = mk(96'h00_0001_0002_0000_0000_0000_00,  6, 16'h000C, 0, 1, 8'd1, 3'd5, 16'h000A, 16'h000C, 16'h002A, 16'h0FA0, 16'h01F4, 16'h03E8, 16'h0005);
    vt[7]  = mk(96'h01_0007_000C_5500_0000_0000_00,  6, 16'h000C, 0, 1, 8'd2, 3'd5, 16'h000A, 16'h000C, 16'h002A, 16'h0FA0, 16'h01F4, 16'h03E8, 16'h0005);
    vt[8]  = mk(96'h03_1100_0000_0000_0000_0000_00,  2, 16'h000C, 0, 1, 8'd3, 3'd5, 16'h000A, 16'h000C, 16'h002A, 16'h0FA0, 16'h01F4, 16'h03E8, 16'h0005);
    vt[9]  = mk(96'h01_0000_0000_0000_0000_0000_00,  1, 16'h000C, 0, 1, 8'd4, 3'd5, 16'h000A, 16'h000C, 16'h002A, 16'h0FA0, 16'h01F4, 16'h03E8, 16'h0005);
    vt[10] = mk(96'h05_000A_0003_0001_0000_0000_00,  7, 16'h000C, 0, 0, 8'd4, 3'd5, 16'h000A, 16'h000C, 16'h002A, 16'h0FA0, 16'h01F4, 16'h03E8, 16'h0005);
    vt[11] = mk(96'hF9_000B_1234_0000_0000_0000_00,  5, 16'h000C, 1, 0, 8'd4, 3'd1, 16'h000B, 16'h1234, 16'h002A, 16'h0FA0, 16'h01F4, 16'h03E8, 16'h0005);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(rx_ready), 32'd0);
    chk("rst_ctrl", 32'({en_MNI, pkt_err, fPktType, drop_cnt}), 32'd0);
    chk_fields("rst", 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_ready", 32'(rx_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      myNodeID = vt[i].node;
      e0 = en_tot; r0 = err_tot;
      send_pkt(vt[i].b, vt[i].n, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("v%0d_en", i), 32'(en_tot - e0), 32'(vt[i].commit));
      chk($sformatf("v%0d_err", i), 32'(err_tot - r0), 32'(vt[i].err));
      chk($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(vt[i].drop));
      chk_fields($sformatf("v%0d", i), vt[i].typ, vt[i].src, vt[i].ch, vt[i].hp,
                 vt[i].emax, vt[i].emin, vt[i].eth, vt[i].ts);
      if (vt[i].commit) chk($sformatf("v%0d_latency", i), 32'(en_cyc), 32'(xfer_cyc));
    end

    // sof at byte 3 of a heartbeat restarts as a CH packet
    e0 = en_tot; r0 = err_tot;
    drive_byte(8'h00, 1, 0); drive_byte(8'h00, 0, 0); drive_byte(8'h05, 0, 0);
    drive_byte(8'h01, 1, 0); drive_byte(8'h00, 0, 0); drive_byte(8'h07, 0, 0);
    drive_byte(8'h00, 0, 0); drive_byte(8'h0D, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("resof_en", 32'(en_tot - e0), 32'd1);
    chk("resof_err", 32'(err_tot - r0), 32'd1);
    chk("resof_drop", 32'(drop_cnt), 32'd5);
    chk_fields("resof", 3'd1, 16'h0007, 16'h000D, 16'h002A, 16'h0FA0, 16'h01F4, 16'h03E8, 16'h0005);

    // Bytes without sof in IDLE are ignored
    e0 = en_tot; r0 = err_tot;
    drive_byte(8'h22, 0, 0); drive_byte(8'h33, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("nosof_en", 32'(en_tot - e0), 32'd0);
    chk("nosof_err", 32'(err_tot - r0), 32'd0);
    chk("nosof_drop", 32'(drop_cnt), 32'd5);

    // rx_valid gaps stall the parser without losing the packet
    e0 = en_tot;
    send_pkt(96'h01_000E_000F_0000_0000_0000_00, 5, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_en", 32'(en_tot - e0), 32'd1);
    chk("stall_latency", 32'(en_cyc), 32'(xfer_cyc));
    chk("stall_src", 32'(src_ID), 32'h000E);
    chk("stall_ch", 32'(ch_ID), 32'h000F);

    // 300 unsupported packets saturate the drop counter
    r0 = err_tot;
    for (int k = 0; k < 300; k++) drive_byte(8'h07, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_drop", 32'(drop_cnt), 32'hFF);
    chk("sat_err", 32'(err_tot - r0), 32'd300);

    // Reset mid-packet
    r0 = err_tot;
    drive_byte(8'h00, 1, 0); drive_byte(8'h00, 0, 0); drive_byte(8'h05, 0, 0);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_ready", 32'(rx_ready), 32'd0);
    chk("mrst_ctrl", 32'({en_MNI, pkt_err, fPktType, drop_cnt}), 32'd0);
    chk_fields("mrst", 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_release_ready", 32'(rx_ready), 32'd1);
    e0 = en_tot;
    drive_byte(8'h00, 0, 0); drive_byte(8'h03, 0, 1);
    send_pkt(96'h01_0021_0022_0000_0000_0000_00, 5, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_en", 32'(en_tot - e0), 32'd1);
    chk("mrst_err", 32'(err_tot - r0), 32'd0);
    chk("mrst_drop", 32'(drop_cnt), 32'd0);
    chk_fields("mrst_pkt", 3'd1, 16'h0021, 16'h0022, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
